// File: rtl/usb_ep_stream_bridge.sv
// usb_ep_stream_bridge: buffered bridge between USB OUT/IN endpoint ports and valid/ready byte streams.
// Define USB_EP_BRIDGE_ZLP_EN to send a zero-length packet after an idle full-size IN packet.
module usb_ep_stream_bridge #(
    parameter int OUT_DEPTH   = 32,
    parameter int IN_DEPTH    = 16,
    parameter int MAX_PKT     = 32,
    parameter int TIMEOUT_W   = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_outEp_req,
    input  logic       i_outEp_grant,
    input  logic       i_outEp_dataAvail,
    output logic       o_outEp_dataGet,
    input  logic [7:0] i_outEp_data,
    output logic       o_inEp_req,
    input  logic       i_inEp_grant,
    input  logic       i_inEp_dataFree,
    output logic       o_inEp_dataPut,
    output logic [7:0] o_inEp_data,
    output logic       o_inEp_dataDone,
    output logic       o_inEp_stall,
    input  logic [7:0] i_in_data,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready
);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int OCW = OAW + 1;
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int ICW = IAW + 1;
    localparam int PW  = $clog2(MAX_PKT + 1);
    localparam logic [OAW:0]           OUT_THR  = OCW'(OUT_DEPTH - MAX_PKT);
    localparam logic [PW-1:0]          PKT_LAST = PW'(MAX_PKT - 1);
    localparam logic [TIMEOUT_W-1:0]   TO_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {O_IDLE, O_REQ, O_GET} oState_t;
    typedef enum logic [2:0] {I_IDLE, I_REQ, I_FILL, I_WAIT, I_DONE} iState_t;

    logic [7:0] outMem [OUT_DEPTH];
    logic [7:0] inMem [IN_DEPTH];
    logic [OAW-1:0] outWr, outRd;
    logic [OAW:0] outCnt;
    logic [IAW-1:0] inWr, inRd;
    logic [IAW:0] inCnt;
    oState_t oState, oNext;
    iState_t iState, iNext;
    logic [PW-1:0] pktCnt;
    logic [TIMEOUT_W-1:0] timer;
    logic outEmpty, inEmpty, outPop, inPush, zlpGo, zlpNow;

    assign outEmpty = outCnt == '0;
    assign inEmpty = inCnt == '0;
    assign o_out_valid = !outEmpty;
    assign o_out_data = outEmpty ? 8'h00 : outMem[outRd];
    assign o_in_ready = !inCnt[IAW];
    assign o_inEp_data = inEmpty ? 8'h00 : inMem[inRd];
    assign o_inEp_stall = 1'b0;
    assign outPop = o_out_valid && i_out_ready;
    assign inPush = i_in_valid && o_in_ready;

`ifdef USB_EP_BRIDGE_ZLP_EN
    logic zlpPending, zlpSent;
    assign zlpNow = zlpPending && inEmpty;
    assign zlpGo = zlpNow && timer >= TO_LAST;
    assign zlpSent = iState == I_REQ && i_inEp_grant && zlpNow;
    always_ff @(posedge i_clk) begin
        if (i_rst) zlpPending <= 1'b0;
        else zlpPending <= o_inEp_dataPut ? pktCnt == PKT_LAST : (inPush || zlpSent) ? 1'b0 : zlpPending;
    end
`else
    assign zlpNow = 1'b0;
    assign zlpGo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (o_outEp_dataGet) outMem[outWr] <= i_outEp_data;
        if (inPush) inMem[inWr] <= i_in_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outWr <= '0;
            outRd <= '0;
            outCnt <= '0;
            inWr <= '0;
            inRd <= '0;
            inCnt <= '0;
            oState <= O_IDLE;
            iState <= I_IDLE;
            pktCnt <= '0;
            timer <= '0;
        end else begin
            outWr <= outWr + OAW'(o_outEp_dataGet);
            outRd <= outRd + OAW'(outPop);
            outCnt <= outCnt + OCW'(o_outEp_dataGet) - OCW'(outPop);
            inWr <= inWr + IAW'(inPush);
            inRd <= inRd + IAW'(o_inEp_dataPut);
            inCnt <= inCnt + ICW'(inPush) - ICW'(o_inEp_dataPut);
            oState <= oNext;
            iState <= iNext;
            pktCnt <= (iState == I_REQ) ? '0 : pktCnt + PW'(o_inEp_dataPut);
            // idle timer also runs in I_IDLE so a pending ZLP can time out there
            timer <= (iState == I_DONE || (iState == I_FILL && iNext == I_WAIT)) ? '0 :
                     (timer != '1 && (iState == I_WAIT || iState == I_IDLE)) ? timer + TIMEOUT_W'(1) : timer;
        end
    end

    // a whole packet must fit before requesting, so dataGet never has to stall mid-packet
    always_comb begin
        oNext = oState;
        o_outEp_req = 1'b0;
        o_outEp_dataGet = 1'b0;
        case (oState)
            O_IDLE: oNext = (i_outEp_dataAvail && outCnt <= OUT_THR) ? O_REQ : O_IDLE;
            O_REQ: begin
                o_outEp_req = 1'b1;
                oNext = i_outEp_grant ? O_GET : O_REQ;
            end
            O_GET: begin
                o_outEp_req = 1'b1;
                o_outEp_dataGet = i_outEp_dataAvail;
                oNext = i_outEp_dataAvail ? O_GET : O_IDLE;
            end
            default: oNext = O_IDLE;
        endcase
    end

    always_comb begin
        iNext = iState;
        o_inEp_req = 1'b0;
        o_inEp_dataPut = 1'b0;
        o_inEp_dataDone = 1'b0;
        case (iState)
            I_IDLE: iNext = (i_inEp_dataFree && (!inEmpty || zlpGo)) ? I_REQ : I_IDLE;
            I_REQ: begin
                o_inEp_req = 1'b1;
                if (i_inEp_grant) iNext = zlpNow ? I_DONE : I_FILL;
            end
            I_FILL: begin
                o_inEp_req = 1'b1;
                o_inEp_dataPut = i_inEp_grant && i_inEp_dataFree && !inEmpty;
                if (o_inEp_dataPut) iNext = (pktCnt == PKT_LAST) ? I_DONE : I_FILL;
                else if (!i_inEp_dataFree) iNext = I_IDLE;
                else if (inEmpty) iNext = I_WAIT;
            end
            I_WAIT: begin
                o_inEp_req = 1'b1;
                iNext = !inEmpty ? I_FILL : (timer == TO_LAST) ? I_DONE : I_WAIT;
            end
            I_DONE: begin
                o_inEp_req = 1'b1;
                o_inEp_dataDone = 1'b1;
                iNext = I_IDLE;
            end
            default: iNext = I_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_ep_stream_bridge.sv
// tb_usb_ep_stream_bridge: scoreboard bench with host endpoint, producer and consumer models.
module tb_usb_ep_stream_bridge;
    localparam int OUT_DEPTH = 32;
    localparam int MAX_PKT = 32;
    localparam int TIMEOUT_CYC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst = 1'b1;
    logic i_outEp_grant = 1'b0, i_outEp_dataAvail = 1'b0, i_inEp_grant = 1'b0, i_inEp_dataFree = 1'b0;
    logic i_in_valid = 1'b0, i_out_ready = 1'b0;
    logic [7:0] i_outEp_data = 8'h00, i_in_data = 8'h00;
    logic o_outEp_req, o_outEp_dataGet, o_inEp_req, o_inEp_dataPut, o_inEp_dataDone, o_inEp_stall;
    logic o_in_ready, o_out_valid;
    logic [7:0] o_inEp_data, o_out_data;

    usb_ep_stream_bridge dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_outEp_req(o_outEp_req), .i_outEp_grant(i_outEp_grant), .i_outEp_dataAvail(i_outEp_dataAvail),
        .o_outEp_dataGet(o_outEp_dataGet), .i_outEp_data(i_outEp_data),
        .o_inEp_req(o_inEp_req), .i_inEp_grant(i_inEp_grant), .i_inEp_dataFree(i_inEp_dataFree),
        .o_inEp_dataPut(o_inEp_dataPut), .o_inEp_data(o_inEp_data), .o_inEp_dataDone(o_inEp_dataDone),
        .o_inEp_stall(o_inEp_stall),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready)
    );

    int nCmp = 0, nErr = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] prodQ[$], inExpQ[$], outExpQ[$], hostBuf[$];
    int hostPkts[$], pktLens[$], expLens[$];
    int hostGap = 0, pktLen = 0, expRises = 0;
    logic [7:0] hostSeq = 8'h00;
    bit inGrantOn = 0, inFreeOn = 0, outGrantOn = 0, outReadyOn = 0, rstOn = 1;
    int inPuts, inReqRises, outGets, firstGetCyc, lastGetCyc, firstValidCyc, lastPutCyc, lastDoneCyc;
    int earlyReq, prevOcc = 0;
    logic prevInReq = 1'b0, prevOutReq = 1'b0;

    task automatic resetStats();
        pktLens.delete();
        pktLen = 0;
        inPuts = 0;
        inReqRises = 0;
        outGets = 0;
        firstGetCyc = -1;
        lastGetCyc = -1;
        firstValidCyc = -1;
        lastPutCyc = -1;
        lastDoneCyc = -1;
        earlyReq = 0;
    endtask

    // Drive on the falling edge, then sample the handshakes the DUT will act on at the next rising edge.
    task automatic tick();
        int occ;
        @(negedge clk);
        if (hostBuf.size() == 0) begin
            if (hostGap > 0) hostGap--;
            else if (hostPkts.size() != 0) begin
                int n = hostPkts.pop_front();
                for (int k = 0; k < n; k++) begin
                    hostBuf.push_back(hostSeq);
                    hostSeq++;
                end
            end
        end
        i_rst = rstOn;
        i_outEp_grant = outGrantOn;
        i_outEp_dataAvail = hostBuf.size() != 0;
        i_outEp_data = hostBuf.size() != 0 ? hostBuf[0] : 8'h00;
        i_inEp_grant = inGrantOn;
        i_inEp_dataFree = inFreeOn;
        i_in_valid = prodQ.size() != 0;
        i_in_data = prodQ.size() != 0 ? prodQ[0] : 8'h00;
        i_out_ready = outReadyOn;
        #1;
        cyc++;
        occ = outExpQ.size();
        if (!rstOn) begin
            if (o_inEp_req && !prevInReq) inReqRises++;
            if (o_outEp_req && !prevOutReq && prevOcc > OUT_DEPTH - MAX_PKT) earlyReq++;
            if (o_inEp_dataPut) begin
                if (inExpQ.size() == 0) check("put_unexp", o_inEp_dataPut, 0);
                else check("in_byte", o_inEp_data, inExpQ.pop_front());
                inPuts++;
                pktLen++;
                lastPutCyc = cyc;
            end
            if (i_in_valid && o_in_ready) begin
                inExpQ.push_back(i_in_data);
                void'(prodQ.pop_front());
            end
            if (o_inEp_dataDone) begin
                pktLens.push_back(pktLen);
                pktLen = 0;
                lastDoneCyc = cyc;
            end
            if (o_out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (o_out_valid && i_out_ready) begin
                if (outExpQ.size() == 0) check("pop_unexp", o_out_valid, 0);
                else check("out_byte", o_out_data, outExpQ.pop_front());
            end
            if (o_outEp_dataGet) begin
                outExpQ.push_back(i_outEp_data);
                if (hostBuf.size() != 0) void'(hostBuf.pop_front());
                if (hostBuf.size() == 0) hostGap = 2;
                outGets++;
                if (firstGetCyc < 0) firstGetCyc = cyc;
                lastGetCyc = cyc;
            end
            prevOcc = occ;
        end
        prevInReq = o_inEp_req;
        prevOutReq = o_outEp_req;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        resetStats();
        repeat (3) tick();
        rstOn = 0;
        tick();

        // reset while in I_FILL with 5 bytes queued
        inFreeOn = 1;
        for (int k = 0; k < 5; k++) prodQ.push_back(8'hA0 + 8'(k));
        repeat (8) tick();
        check("t1_req_wait", o_inEp_req, 1);
        inGrantOn = 1;
        tick();
        inGrantOn = 0;
        tick();
        check("t1_fill_noput", o_inEp_dataPut, 0);
        check("t1_fill_req", o_inEp_req, 1);
        rstOn = 1;
        tick();
        rstOn = 0;
        tick();
        check("t1_rst_ctl", {o_outEp_req, o_outEp_dataGet, o_inEp_req, o_inEp_dataPut,
                             o_inEp_dataDone, o_inEp_stall, o_in_ready, o_out_valid}, 8'b0000_0010);
        check("t1_rst_in_data", o_inEp_data, 0);
        check("t1_rst_out_data", o_out_data, 0);
        inExpQ.delete();
        resetStats();
        inGrantOn = 1;
        repeat (10) tick();
        check("t1_discard_puts", inPuts, 0);
        check("t1_no_req", inReqRises, 0);

        // host sends 10 bytes, consumer always ready
        resetStats();
        outGrantOn = 1;
        outReadyOn = 1;
        hostPkts.push_back(10);
        for (int i = 0; i < 100 && !(outGets == 10 && outExpQ.size() == 0 && hostBuf.size() == 0); i++) tick();
        check("t2_gets", outGets, 10);
        check("t2_get_span", lastGetCyc - firstGetCyc, 9);
        check("t2_first_lat", firstValidCyc - firstGetCyc, 1);
        check("t2_drained", outExpQ.size(), 0);

        // 3 bytes then idle: close on timeout
        resetStats();
        for (int k = 0; k < 3; k++) prodQ.push_back(8'h31 + 8'(k));
        for (int i = 0; i < 100 && pktLens.size() == 0; i++) tick();
        check("t3_npkts", pktLens.size(), 1);
        if (pktLens.size() != 0) check("t3_len", pktLens[0], 3);
        check("t3_puts", inPuts, 3);
        check("t3_timeout", lastDoneCyc - lastPutCyc, TIMEOUT_CYC + 2);
        tick();
        check("t3_req_drop", o_inEp_req, 0);

        // 70 bytes streamed: 32/32/6
        resetStats();
        for (int k = 0; k < 70; k++) prodQ.push_back(8'(k * 3 + 1));
        for (int i = 0; i < 600 && pktLens.size() < 3; i++) tick();
        repeat (40) tick();
        expLens = '{32, 32, 6};
        check("t4_npkts", pktLens.size(), expLens.size());
        for (int k = 0; k < expLens.size() && k < pktLens.size(); k++) check("t4_len", pktLens[k], expLens[k]);
        check("t4_left", inExpQ.size(), 0);

        // exactly MAX_PKT bytes then idle
        resetStats();
        for (int k = 0; k < 32; k++) prodQ.push_back(8'hC0 ^ 8'(k));
`ifdef USB_EP_BRIDGE_ZLP_EN
        expLens = '{32, 0};
        expRises = 2;
`else
        expLens = '{32};
        expRises = 1;
`endif
        repeat (200) tick();
        check("t5_npkts", pktLens.size(), expLens.size());
        for (int k = 0; k < expLens.size() && k < pktLens.size(); k++) check("t5_len", pktLens[k], expLens[k]);
        check("t5_reqs", inReqRises, expRises);
        check("t5_puts", inPuts, 32);

        // consumer stalled while host offers two full packets
        resetStats();
        outReadyOn = 0;
        hostPkts.push_back(32);
        hostPkts.push_back(32);
        repeat (120) tick();
        check("t6_first_only", outGets, 32);
        check("t6_no_req", o_outEp_req, 0);
        outReadyOn = 1;
        for (int i = 0; i < 400 && !(outGets == 64 && outExpQ.size() == 0); i++) tick();
        check("t6_gets", outGets, 64);
        check("t6_drained", outExpQ.size(), 0);
        check("t6_early_req", earlyReq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
